approx_fp_mul_pipe: RTL and testbench

APPROX_FP_MUL_PIPE -- requirements
Module: approx_fp_mul_pipe

---
 rtl/approx_fp_pkg.sv | 21 ++
 rtl/booth_trunc_mul.sv | 52 +++++
 rtl/approx_fp_mul_pipe.sv | 199 +++++++++++++++++++
 tb/tb_approx_fp_mul_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_fp_pkg.sv
// Shared definitions for the approximate floating-point multiplier: precision
// mode encodings, out_flags bit positions and the exponent bias helper.
package approx_fp_pkg;

  typedef enum logic [1:0] {
    PM_EXACT     = 2'd0,
    PM_EXP_TRUNC = 2'd1,
    PM_FIX_TRUNC = 2'd2,
    PM_EXACT_ALT = 2'd3
  } prec_mode_e;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_INF    = 1;
  localparam int FLAG_NAN    = 2;
  localparam int FLAG_APPROX = 3;

  function automatic int bias_f(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/booth_trunc_mul.sv
// Radix-4 Booth multiplier of two unsigned (MAN_W+1)-bit significands; each
// shifted partial product loses its columns below k before summation.
module booth_trunc_mul #(
  parameter int MAN_W     = 10,
  parameter int TRUNC_MAX = 7
) (
  input  logic [MAN_W:0]                 a,
  input  logic [MAN_W:0]                 b,
  input  logic [$clog2(MAN_W+1)-1:0]     k,
  output logic [2*(MAN_W+1)-1:0]         prod
);

  localparam int NB = MAN_W + 1;
  localparam int PW = 2 * NB;
  localparam int SW = PW + 2;
  localparam int ND = (NB + 2) / 2;
  localparam int KW = $clog2(MAN_W + 1);

  logic [2*ND:0]          bx;
  logic [KW-1:0]          keff;
  logic [SW-1:0]          mask;
  logic signed [SW-1:0]   a_s;
  logic signed [SW-1:0]   pp;
  logic signed [SW-1:0]   acc;
  logic                   unused_acc;

  assign bx   = {{(2*ND-NB){1'b0}}, b, 1'b0};
  assign keff = (k > KW'(TRUNC_MAX)) ? KW'(TRUNC_MAX) : k;
  assign mask = {SW{1'b1}} << keff;
  assign a_s  = $signed(SW'(a));

  // Masking every partial product leaves product bits [k-1:0] zero as well.
  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < ND; i++) begin
      case ({bx[2*i+2], bx[2*i+1], bx[2*i]})
        3'b001, 3'b010: pp = a_s;
        3'b011:         pp = a_s <<< 1;
        3'b100:         pp = -(a_s <<< 1);
        3'b101, 3'b110: pp = -a_s;
        default:        pp = '0;
      endcase
      pp  = $signed((pp <<< (2*i)) & mask);
      acc = acc + pp;
    end
  end

  assign prod       = acc[PW-1:0];
  assign unused_acc = ^acc[SW-1:PW];

endmodule

// File: rtl/approx_fp_mul_pipe.sv
// Three-stage approximate FP multiplier (unpack / truncated Booth / normalize).
// Define APPROX_FP_MUL_EXC_EN to enable zero/inf/NaN and over/underflow handling.
module approx_fp_mul_pipe
  import approx_fp_pkg::*;
#(
  parameter int EXP_W     = 5,
  parameter int MAN_W     = 10,
  parameter int TRUNC_MAX = 7,
  parameter int TAG_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [1:0]             prec_mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_p,
  output logic [3:0]             out_flags,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int NB   = MAN_W + 1;
  localparam int PW   = 2 * NB;
  localparam int KW   = $clog2(MAN_W + 1);
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = bias_f(EXP_W);

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  // A stage loads when it is empty or its content moves on this edge.
  assign ld3      = ~v3_q | out_ready;
  assign ld2      = ~v2_q | ld3;
  assign ld1      = ~v1_q | ld2;
  assign in_ready = ld1 & ~rst;

  // ---------------- S1: unpack, sign, exponent sum, k select
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     ma, mb;
  logic [XW-1:0]        esum_d, e_mag;
  logic signed [XW-1:0] e_unb;
  logic [KW-1:0]        k_d;

  assign {sa, ea, ma} = in_a;
  assign {sb, eb, mb} = in_b;

  always_comb begin
    esum_d = XW'(ea) + XW'(eb);
    e_unb  = $signed(esum_d - XW'(2 * BIAS));
    e_mag  = e_unb[XW-1] ? $unsigned(-e_unb) : $unsigned(e_unb);
    k_d    = '0;
    case (prec_mode_e'(prec_mode))
      PM_EXP_TRUNC: k_d = ((e_mag >> 1) > XW'(TRUNC_MAX)) ? KW'(TRUNC_MAX) : KW'(e_mag >> 1);
      PM_FIX_TRUNC: k_d = KW'(TRUNC_MAX);
      PM_EXACT, PM_EXACT_ALT: k_d = '0;
      default: k_d = '0;
    endcase
  end

  logic             sign1_q;
  logic [XW-1:0]    esum1_q;
  logic [NB-1:0]    ma1_q, mb1_q;
  logic [KW-1:0]    k1_q;
  logic [TAG_W-1:0] tag1_q;

  // ---------------- S2: truncated Booth product
  logic [PW-1:0]    prod_s2;
  logic             sign2_q, approx2_q;
  logic [XW-1:0]    esum2_q;
  logic [PW-1:0]    prod2_q;
  logic [TAG_W-1:0] tag2_q;

  booth_trunc_mul #(.MAN_W(MAN_W), .TRUNC_MAX(TRUNC_MAX)) u_mul (
    .a    (ma1_q),
    .b    (mb1_q),
    .k    (k1_q),
    .prod (prod_s2)
  );

`ifdef APPROX_FP_MUL_EXC_EN
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [MAN_W-1:0]     QNAN_MAN = MAN_W'(1) << (MAN_W - 1);

  logic za, zb, ia, ib, na, nb;
  logic zero_d, inf_d, nan_d;
  logic zero1_q, inf1_q, nan1_q, zero2_q, inf2_q, nan2_q;

  // Exponent zero is treated as zero (subnormals flush).
  always_comb begin
    za     = (ea == '0);
    zb     = (eb == '0);
    ia     = (ea == '1) && (ma == '0);
    ib     = (eb == '1) && (mb == '0);
    na     = (ea == '1) && (ma != '0);
    nb     = (eb == '1) && (mb != '0);
    nan_d  = na | nb | (ia & zb) | (za & ib);
    inf_d  = (ia | ib) & ~nan_d;
    zero_d = (za | zb) & ~nan_d & ~inf_d;
  end
`endif

  // ---------------- S3: normalize and pack
  logic                 norm;
  logic [MAN_W-1:0]     man_n;
  logic signed [XW-1:0] exp_n;
  logic [W-1:0]         p_d;
  logic [3:0]           flags_d;
  logic                 unused_s3;

  always_comb begin
    norm    = prod2_q[PW-1];
    man_n   = norm ? prod2_q[PW-2 -: MAN_W] : prod2_q[PW-3 -: MAN_W];
    exp_n   = $signed(esum2_q - XW'(BIAS) + XW'(norm));
    p_d     = {sign2_q, exp_n[EXP_W-1:0], man_n};
    flags_d = '0;
    flags_d[FLAG_APPROX] = approx2_q;
`ifdef APPROX_FP_MUL_EXC_EN
    if (nan2_q) begin
      p_d = {sign2_q, {EXP_W{1'b1}}, QNAN_MAN};
      flags_d[FLAG_NAN] = 1'b1;
    end else if (inf2_q || (exp_n >= EXP_MAX)) begin
      p_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d[FLAG_INF] = 1'b1;
    end else if (zero2_q || (exp_n <= 0)) begin
      p_d = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
      flags_d[FLAG_ZERO] = 1'b1;
    end
`endif
  end

  assign unused_s3 = ^{prod2_q[MAN_W-1:0], exp_n[XW-1:EXP_W]};

  logic [W-1:0]     p_q;
  logic [3:0]       flags_q;
  logic [TAG_W-1:0] tag3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p_q     <= '0;
      flags_q <= '0;
      tag3_q  <= '0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          sign1_q <= sa ^ sb;
          esum1_q <= esum_d;
          ma1_q   <= {1'b1, ma};
          mb1_q   <= {1'b1, mb};
          k1_q    <= k_d;
          tag1_q  <= in_tag;
`ifdef APPROX_FP_MUL_EXC_EN
          zero1_q <= zero_d;
          inf1_q  <= inf_d;
          nan1_q  <= nan_d;
`endif
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sign2_q   <= sign1_q;
          esum2_q   <= esum1_q;
          prod2_q   <= prod_s2;
          approx2_q <= (k1_q != '0);
          tag2_q    <= tag1_q;
`ifdef APPROX_FP_MUL_EXC_EN
          zero2_q <= zero1_q;
          inf2_q  <= inf1_q;
          nan2_q  <= nan1_q;
`endif
        end
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          p_q     <= p_d;
          flags_q <= flags_d;
          tag3_q  <= tag2_q;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_p     = p_q;
  assign out_flags = flags_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_approx_fp_mul_pipe.sv
// Directed bench for approx_fp_mul_pipe at default parameters; exception
// vectors follow APPROX_FP_MUL_EXC_EN when it is defined for the build.
module tb_approx_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_p;
  logic [1:0]  prec_mode;
  logic [3:0]  in_tag, out_tag, out_flags;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] bp_a [4];
  logic [15:0] bp_b [4];
  logic [1:0]  bp_m [4];
  logic [15:0] bp_p [4];
  logic [3:0]  bp_f [4];
  int          got, saw;

  always #5 clk = ~clk;

  approx_fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .prec_mode (prec_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
      end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                       input logic [3:0] t);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    prec_mode = m;
    in_tag    = t;
  endtask

  // Single op into an empty pipe with out_ready high; result due in cycle 3.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, input logic [3:0] t,
                        input logic [15:0] ep, input logic [3:0] ef);
    drive(a, b, m, t);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({nm, "_lat2"}, 32'(out_valid), 32'd0);
    tick();
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_p"}, 32'(out_p), 32'(ep));
    chk({nm, "_flags"}, 32'(out_flags), 32'(ef));
    chk({nm, "_tag"}, 32'(out_tag), 32'(t));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bp_a[0] = 16'h3C00; bp_b[0] = 16'h3C00; bp_m[0] = 2'd0; bp_p[0] = 16'h3C00; bp_f[0] = 4'h0;
    bp_a[1] = 16'h4000; bp_b[1] = 16'h4200; bp_m[1] = 2'd0; bp_p[1] = 16'h4600; bp_f[1] = 4'h0;
    bp_a[2] = 16'h3E00; bp_b[2] = 16'h3E00; bp_m[2] = 2'd0; bp_p[2] = 16'h4080; bp_f[2] = 4'h0;
    bp_a[3] = 16'h3C7F; bp_b[3] = 16'h3D55; bp_m[3] = 2'd2; bp_p[3] = 16'h3DFD; bp_f[3] = 4'h8;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; prec_mode = '0; in_tag = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_p", 32'(out_p), 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_rdy", 32'(in_ready), 32'd1);
    tick();

    run_op("one",        16'h3C00, 16'h3C00, 2'd0, 4'h1, 16'h3C00, 4'h0);
    run_op("two_three",  16'h4000, 16'h4200, 2'd0, 4'h2, 16'h4600, 4'h0);
    run_op("norm_shift", 16'h3E00, 16'h3E00, 2'd0, 4'h3, 16'h4080, 4'h0);
    run_op("m1_big_e",   16'h5BFF, 16'h5BFF, 2'd1, 4'h4, 16'h7BFE, 4'h8);
    run_op("m2_trunc",   16'h3C7F, 16'h3D55, 2'd2, 4'h5, 16'h3DFD, 4'h8);
    run_op("m0_exact",   16'h3C7F, 16'h3D55, 2'd0, 4'h6, 16'h3DFE, 4'h0);
    run_op("m1_e0",      16'h3C7F, 16'h3D55, 2'd1, 4'h7, 16'h3DFE, 4'h0);
    run_op("m1_neg_e",   16'h207F, 16'h2155, 2'd1, 4'h8, 16'h05FD, 4'h8);
    run_op("m2_one",     16'h3C00, 16'h3C00, 2'd2, 4'h9, 16'h3C00, 4'h8);
    run_op("neg",        16'hC000, 16'h4200, 2'd0, 4'hA, 16'hC600, 4'h0);
    run_op("m3_negneg",  16'hBC00, 16'hBC00, 2'd3, 4'hB, 16'h3C00, 4'h0);
`ifdef APPROX_FP_MUL_EXC_EN
    run_op("inf_x_zero", 16'h7C00, 16'h0000, 2'd0, 4'hC, 16'h7E00, 4'h4);
    run_op("overflow",   16'h7BFF, 16'h7BFF, 2'd0, 4'hD, 16'h7C00, 4'h2);
    run_op("underflow",  16'h0400, 16'h0400, 2'd0, 4'hE, 16'h0000, 4'h1);
`else
    run_op("wrap_inf0",  16'h7C00, 16'h0000, 2'd0, 4'hC, 16'h4000, 4'h0);
    run_op("wrap_ovf",   16'h7BFF, 16'h7BFF, 2'd0, 4'hD, 16'h3BFE, 4'h0);
    run_op("wrap_unf",   16'h0400, 16'h0400, 2'd0, 4'hE, 16'h4C00, 4'h0);
`endif

    // Back-pressure: three ops fill the pipe, the fourth waits.
    out_ready = 1'b0;
    drive(bp_a[0], bp_b[0], bp_m[0], 4'd1);
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    tick();
    drive(bp_a[1], bp_b[1], bp_m[1], 4'd2);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(bp_a[2], bp_b[2], bp_m[2], 4'd3);
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    drive(bp_a[3], bp_b[3], bp_m[3], 4'd4);
    chk("bp_full", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_p_a", 32'(out_p), 32'(bp_p[0]));
    tick();
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_p_b", 32'(out_p), 32'(bp_p[0]));
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_resume_rdy", 32'(in_ready), 32'd1);
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      if (out_valid) begin
        chk($sformatf("bp_p%0d", got), 32'(out_p), 32'(bp_p[got]));
        chk($sformatf("bp_f%0d", got), 32'(out_flags), 32'(bp_f[got]));
        chk($sformatf("bp_tag%0d", got), 32'(out_tag), 32'(got + 1));
        got++;
      end
      tick();
      if (cyc == 0) in_valid = 1'b0;
    end
    chk("bp_count", 32'(got), 32'd4);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with three ops stalled in the pipe.
    out_ready = 1'b0;
    drive(16'h4000, 16'h4200, 2'd0, 4'h9);
    tick();
    drive(16'h3E00, 16'h3E00, 2'd0, 4'hA);
    tick();
    drive(16'hC000, 16'h4200, 2'd0, 4'hB);
    tick();
    in_valid = 1'b0;
    chk("rm_pre_valid", 32'(out_valid), 32'd1);
    chk("rm_pre_p", 32'(out_p), 32'h4600);
    rst = 1'b1;
    #1;
    chk("rm_rdy_in_rst", 32'(in_ready), 32'd0);
    tick();
    chk("rm_valid", 32'(out_valid), 32'd0);
    chk("rm_p", 32'(out_p), 32'd0);
    chk("rm_flags", 32'(out_flags), 32'd0);
    chk("rm_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    chk("rm_rel_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    saw = 0;
    repeat (8) begin
      tick();
      if (out_valid) saw++;
    end
    chk("rm_none_emerge", 32'(saw), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
